// File: rtl/maxpool_sched.sv
// Job scheduler for a 2x2 max-pool engine: streams each channel from the input memory and
// collects the pooled results into the output memory. Optional cycle counter: MAXPOOL_SCHED_PERF_EN.
module maxpool_sched #(
  parameter int MAP_WIDTH = 28,
  parameter int NUM_CH    = 6,
  localparam int OUT_DIM  = MAP_WIDTH / 2,
  localparam int PIX      = MAP_WIDTH * MAP_WIDTH,
  localparam int OPIX     = OUT_DIM * OUT_DIM,
  localparam int IN_AW    = $clog2(NUM_CH * PIX),
  localparam int OUT_AW   = $clog2(NUM_CH * OPIX),
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [CH_W-1:0]   ch_idx,
  output logic              rd_en,
  output logic [IN_AW-1:0]  rd_addr,
  input  logic [7:0]        rd_data,
  output logic              eng_rst,
  output logic              eng_valid,
  output logic [7:0]        eng_pixel,
  input  logic              eng_valid_out,
  input  logic [7:0]        eng_pixel_out,
  output logic              wr_en,
  output logic [OUT_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
`ifdef MAXPOOL_SCHED_PERF_EN
  ,
  output logic [31:0]       cyc_count
`endif
);

  localparam int RC_W = $clog2(PIX);
  localparam int WC_W = $clog2(OPIX + 1);

  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, NEXT, FIN} state_t;

  state_t          state_q, state_d;
  logic [RC_W-1:0] rd_cnt;
  logic [WC_W-1:0] wr_cnt;
  logic            accept;
  logic            last_ch;

  // Results are only collected while a channel is in flight; once the channel's
  // quota is written, further engine outputs are dropped rather than wrapping.
  assign accept  = eng_valid_out && (state_q == FEED || state_q == DRAIN) &&
                   (wr_cnt != WC_W'(OPIX));
  assign last_ch = (ch_idx == CH_W'(NUM_CH - 1));

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign rd_en     = (state_q == FEED) && !stall;
  assign rd_addr   = IN_AW'(int'(ch_idx) * PIX + int'(rd_cnt));
  assign eng_pixel = eng_valid ? rd_data : '0;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = CLR;
      CLR:   state_d = FEED;
      FEED:  if (!stall && rd_cnt == RC_W'(PIX - 1)) state_d = DRAIN;
      DRAIN: if ((wr_cnt == WC_W'(OPIX)) || (accept && wr_cnt == WC_W'(OPIX - 1)))
               state_d = NEXT;
      NEXT:  state_d = last_ch ? FIN : CLR;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      ch_idx    <= '0;
      eng_rst   <= 1'b1;
      eng_valid <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state_q   <= state_d;
      eng_rst   <= (state_d == CLR);
      eng_valid <= rd_en;
      wr_en     <= accept;

      if (state_q == CLR)  rd_cnt <= '0;
      else if (rd_en)      rd_cnt <= rd_cnt + RC_W'(1);

      if (state_q == CLR)  wr_cnt <= '0;
      else if (accept)     wr_cnt <= wr_cnt + WC_W'(1);

      if (accept) begin
        wr_addr <= OUT_AW'(int'(ch_idx) * OPIX + int'(wr_cnt));
        wr_data <= eng_pixel_out;
      end

      if (state_q == NEXT && !last_ch) ch_idx <= ch_idx + CH_W'(1);
      else if (state_q == FIN)         ch_idx <= '0;
    end
  end

`ifdef MAXPOOL_SCHED_PERF_EN
  // Counts busy cycles of the current job; saturates and holds after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cyc_count <= '0;
    else if (state_q == IDLE && start)     cyc_count <= '0;
    else if (busy && cyc_count != '1)      cyc_count <= cyc_count + 32'd1;
  end
`endif

endmodule

// File: doc/maxpool_sched.md
MAXPOOL_SCHED -- requirements
Module: maxpool_sched

Interface
REQ-001 The block SHALL have parameter MAP_WIDTH, default 28: input feature-map side length in pixels, even, at least 4.
REQ-002 The block SHALL have parameter NUM_CH, default 6: number of channels pooled per job.
REQ-003 The block SHALL derive localparams OUT_DIM=MAP_WIDTH/2, IN_AW=clog2(NUM_CH*MAP_WIDTH^2) and OUT_AW=clog2(NUM_CH*OUT_DIM^2).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  job request; sampled only in IDLE.
REQ-007 stall  in  1  pauses input reads while high.
REQ-008 busy  out  1  high from the cycle after start is accepted until done.
REQ-009 done  out  1  one-cycle pulse at job completion.
REQ-010 ch_idx  out  clog2(NUM_CH)  current channel.
REQ-011 rd_en / rd_addr  out  1 / IN_AW  input-memory read request and address; memory read latency is 1 cycle.
REQ-012 rd_data  in  8  signed pixel returned by the input memory.
REQ-013 eng_rst  out  1  active-high synchronous reset to the maxpool engine.
REQ-014 eng_valid / eng_pixel  out  1 / 8  pixel stream to the engine.
REQ-015 eng_valid_out / eng_pixel_out  in  1 / 8  pooled results from the engine.
REQ-016 wr_en / wr_addr / wr_data  out  1 / OUT_AW / 8  output-memory write port.

Function
REQ-017 The FSM SHALL have the states IDLE, CLR, FEED, DRAIN, NEXT and FIN.
REQ-018 IDLE with start=1 SHALL go to CLR; start in any other state SHALL be ignored.
REQ-019 CLR SHALL last exactly 1 cycle with eng_rst=1, clearing the per-channel read and write counters, then go to FEED.
REQ-020 FEED: each cycle with stall=0, rd_en=1 and rd_addr=ch_idx*MAP_WIDTH^2+rd_cnt, then rd_cnt increments; with stall=1, rd_en=0 and rd_cnt holds.
REQ-021 FEED SHALL go to DRAIN after issuing read MAP_WIDTH^2-1.
REQ-022 eng_valid SHALL be rd_en registered by 1 cycle, and eng_pixel SHALL equal rd_data.
REQ-023 wr_en, wr_data and wr_addr SHALL be eng_valid_out and eng_pixel_out registered by 1 cycle, with wr_addr=ch_idx*OUT_DIM^2+wr_cnt.
REQ-024 DRAIN SHALL go to NEXT on the cycle the write with wr_cnt=OUT_DIM^2-1 is issued; stall SHALL be ignored in DRAIN.
REQ-025 NEXT SHALL go to FIN when ch_idx=NUM_CH-1; otherwise NEXT SHALL increment ch_idx and go to CLR.
REQ-026 FIN SHALL assert done=1 for 1 cycle, clear busy and ch_idx, and return to IDLE.
REQ-027 eng_valid_out arriving when wr_cnt=OUT_DIM^2 SHALL be dropped, with no write and no counter wrap.
REQ-028 Engine outputs arriving during FEED SHALL be written normally; each write SHALL be independent of stall.

Reset
REQ-029 With rst_n=0 the block SHALL, asynchronously: enter state IDLE; force busy, done, rd_en, eng_valid and wr_en to 0; force ch_idx, all counters, rd_addr, wr_addr, wr_data and eng_pixel to 0; force eng_rst to 1.
REQ-030 eng_rst SHALL drop to 0 on the first clock edge after rst_n deasserts.
REQ-031 Reset mid-job SHALL abandon the job without a done pulse, and a later start SHALL run a complete, correct job.

Configuration
REQ-032 The macro MAXPOOL_SCHED_PERF_EN, when defined, SHALL add output cyc_count (32 bits), reset to 0.
REQ-033 With the macro, cyc_count SHALL clear on start acceptance, increment every cycle while busy=1, saturate at all-ones, and hold after done.
REQ-034 Without the macro, the port and the counter logic SHALL be absent, with all other behaviour identical.

Verification
REQ-035 MAP_WIDTH=4, NUM_CH=2, input memory holding value = address (0..31) -> writes addr0..7 = 5,7,13,15,21,23,29,31, exactly one done pulse.
REQ-036 Same setup with stall=1 for 3 cycles mid-FEED of channel 0 -> identical writes, and (with the macro) cyc_count exactly 3 greater than the unstalled run.
REQ-037 Channel of -128 everywhere except pixel 5 = -1 -> write0 = -1, other writes = -128, confirming signed comparison.
REQ-038 start pulsed during FEED and DRAIN -> no restart, 8 writes total, a single done pulse.
REQ-039 rst_n asserted during FEED of channel 1 -> all outputs at their reset values within the reset cycle, no done pulse; re-start -> REQ-035 results.
REQ-040 Spurious eng_valid_out injected after the last write of a channel -> no extra wr_en, correct channel advance.
